grf_scoreboard: RTL and testbench
=================================

Name: grf_scoreboard

Overview:
- Parametrised successor of the pipeline general register file.
- Provides NUM_RD combinational read ports with write-to-read bypass and a hardwired zero register.
- Adds a per-register pending-write scoreboard: saturating in-flight counters, incremented at issue and decremented at write-back. Hazard logic uses it to stall consumers of not-yet-written registers.
- Sits between the decode/issue stage (reads, issue) and the write-back stage (commit).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of independent read ports.
- CNT_W, 2, width of each pending-write counter; maximum count is 2**CNT_W-1.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- pause  input  1  freeze: blocks write, issue and retire when 1.
- reg_we  input  1  write-back enable (also retire strobe).
- reg_wa  input  ADDR_W  write-back address.
- reg_wd  input  DATA_W  write-back data.
- iss_valid  input  1  an instruction with a destination register issues this cycle.
- iss_adr  input  ADDR_W  destination register of the issuing instruction.
- reg_ra  input  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
- reg_rd  output  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
- reg_busy  output  NUM_RD  port k's register has an outstanding write not satisfied this cycle.
- sb_err  output  1  sticky scoreboard overflow/underflow flag.

Behaviour:
- Definitions: commit = reg_we & !pause & (reg_wa != 0); issue = iss_valid & !pause & (iss_adr != 0).
- Reset (synchronous, posedge with reset=1):
  - All DEPTH registers cleared to 0.
  - All counters cleared to 0; sb_err cleared to 0.
  - reset has priority over commit and issue in the same cycle.
- Outputs after reset: reg_rd all 0, reg_busy all 0, sb_err 0.
- Register 0:
  - Always reads 0.
  - Never written, never counted, reg_busy always 0 for it.
- Write: on posedge with commit, mem[reg_wa] <= reg_wd. Write latency is 1 cycle; the value is readable from the array the next cycle.
- Read (combinational, zero latency), port k:
  - ra = 0 -> 0.
  - Else if commit and ra == reg_wa -> reg_wd (bypass).
  - Else -> mem[ra].
  - Bypass is suppressed when pause=1; the port then returns the old array value.
- Counter update on posedge, for register r:
  - issue to r only -> cnt[r]+1.
  - commit to r only -> cnt[r]-1.
  - Both in the same cycle -> cnt[r] unchanged.
  - Issue and commit to different registers update both independently.
- Overflow: issue-only to r with cnt[r] = max -> cnt saturates (unchanged), sb_err <= 1.
- Underflow: commit-only to r with cnt[r] = 0 -> cnt unchanged, sb_err <= 1. The data write still occurs.
- sb_err is sticky until reset.
- reg_busy[k] (combinational):
  - Asserted when ra != 0 and the effective count is nonzero.
  - Effective count = cnt[ra] - (commit & reg_wa == ra).
  - Same-cycle issue to ra does not assert busy; it becomes busy the next cycle.
- pause=1: no state changes except reset. Reads still operate without bypass.
- Reset mid-operation: outstanding counts are discarded. A subsequent commit without a prior issue flags underflow.
- No FSM beyond the counters. Counter array is DEPTH x CNT_W; implementation uses a generate loop over read ports.

Test Plan:
- Reset, then read ports 0/1 at addrs 5/0 -> reg_rd = 0/0, reg_busy = 00, sb_err = 0.
- Commit reg_wa=3, reg_wd=32'h1234_5678 while port0 reads 3 -> same-cycle reg_rd[0] = 32'h1234_5678 via bypass. Next cycle with reg_we=0 -> still 32'h1234_5678. Commit to reg 0 -> reg 0 reads 0.
- Issue reg 7 twice on consecutive cycles -> busy for 7 = 1 from cycle after the first issue. First commit to 7 -> still busy (effective count 1). Second commit -> busy 0 in that same cycle, read shows committed data.
- Simultaneous issue and commit to reg 9 with cnt=1 -> cnt stays 1, busy stays 1. Issue 4 times with CNT_W=2 -> cnt saturates at 3 on the 4th, sb_err = 1 and stays set.
- Commit reg 12 with cnt=0 -> data written (reads back correctly), sb_err = 1, cnt stays 0.
- pause=1 with reg_we=1, reg_wa=4, reg_wd=32'hDEAD_BEEF and iss_valid=1 to reg 4 -> port reading 4 returns old value, no array or count change. Deassert pause -> commit and issue both take effect.

Source files
------------

// File: rtl/grf_scoreboard.sv
// General register file with bypassed combinational reads, hardwired zero register
// and a per-register saturating pending-write scoreboard for hazard detection.
module grf_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pause,
    input  logic                     reg_we,
    input  logic [ADDR_W-1:0]        reg_wa,
    input  logic [DATA_W-1:0]        reg_wd,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_adr,
    input  logic [NUM_RD*ADDR_W-1:0] reg_ra,
    output logic [NUM_RD*DATA_W-1:0] reg_rd,
    output logic [NUM_RD-1:0]        reg_busy,
    output logic                     sb_err
);

    localparam int               DEPTH   = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  cnt [DEPTH];

    logic             commit;
    logic             issue;
    logic [DEPTH-1:0] inc_hit;
    logic [DEPTH-1:0] dec_hit;

    assign commit = reg_we & ~pause & (reg_wa != '0);
    assign issue  = iss_valid & ~pause & (iss_adr != '0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        if (issue)
            inc_hit[iss_adr] = 1'b1;
        if (commit)
            dec_hit[reg_wa] = 1'b1;
    end

    // NOTE: the register array is cleared by reset because software relies on a zeroed file;
    // sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
                cnt[i] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (commit)
                mem[reg_wa] <= reg_wd;
            // Issue and retire to the same register cancel; errors leave the count untouched.
            for (int r = 1; r < DEPTH; r++) begin
                unique case ({inc_hit[r], dec_hit[r]})
                    2'b10: begin
                        if (cnt[r] == CNT_MAX)
                            sb_err <= 1'b1;
                        else
                            cnt[r] <= cnt[r] + 1'b1;
                    end
                    2'b01: begin
                        if (cnt[r] == '0)
                            sb_err <= 1'b1;
                        else
                            cnt[r] <= cnt[r] - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              byp;

        assign ra  = reg_ra[k*ADDR_W +: ADDR_W];
        assign byp = commit & (ra == reg_wa);

        assign reg_rd[k*DATA_W +: DATA_W] = (ra == '0) ? '0 :
                                            byp        ? reg_wd : mem[ra];

        // A retiring write satisfies one outstanding count; an empty count is never busy.
        assign reg_busy[k] = (ra != '0) &&
                             ((cnt[ra] > CNT_W'(1)) || ((cnt[ra] == CNT_W'(1)) && !byp));
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Self-checking bench: a behavioural register-file model pushes expected outputs
// into a queue as stimulus is driven; they are popped and compared mid-cycle.
module tb_grf_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int CNT_W  = 2;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int CMAX   = 2 ** CNT_W - 1;

    logic                     clk = 1'b0;
    logic                     reset, pause, reg_we, iss_valid;
    logic [ADDR_W-1:0]        reg_wa, iss_adr;
    logic [DATA_W-1:0]        reg_wd;
    logic [NUM_RD*ADDR_W-1:0] reg_ra;
    logic [NUM_RD*DATA_W-1:0] reg_rd;
    logic [NUM_RD-1:0]        reg_busy;
    logic                     sb_err;

    grf_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .pause(pause), .reg_we(reg_we), .reg_wa(reg_wa),
        .reg_wd(reg_wd), .iss_valid(iss_valid), .iss_adr(iss_adr), .reg_ra(reg_ra),
        .reg_rd(reg_rd), .reg_busy(reg_busy), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;   // 0/1: read data of port, 2: busy vector, 3: sb_err
        logic [31:0] exp;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_mem [DEPTH];
    int          m_cnt [DEPTH];
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic m_commit();
        return reg_we && !pause && reg_wa != 0;
    endfunction

    function automatic logic m_issue();
        return iss_valid && !pause && iss_adr != 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
    endtask

    // Expected outputs for the inputs currently applied.
    task automatic push_expected(input string tag);
        logic [NUM_RD-1:0] busy;
        busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] ra;
            logic [31:0]       rd;
            int                eff;
            ra  = reg_ra[k*ADDR_W +: ADDR_W];
            eff = m_cnt[ra] - ((m_commit() && reg_wa == ra) ? 1 : 0);
            if (ra == 0)                        rd = '0;
            else if (m_commit() && reg_wa == ra) rd = reg_wd;
            else                                rd = m_mem[ra];
            busy[k] = (ra != 0) && (eff > 0);
            exp_q.push_back('{$sformatf("%s.rd%0d", tag, k), k, rd});
        end
        exp_q.push_back('{{tag, ".busy"}, 2, 32'(busy)});
        exp_q.push_back('{{tag, ".err"}, 3, 32'(m_err)});
    endtask

    task automatic model_clock();
        if (reset) begin
            model_reset();
        end else begin
            logic c, i;
            c = m_commit();
            i = m_issue();
            if (c) m_mem[reg_wa] = reg_wd;
            if (i && !(c && reg_wa == iss_adr)) begin
                if (m_cnt[iss_adr] == CMAX) m_err = 1'b1;
                else m_cnt[iss_adr]++;
            end
            if (c && !(i && reg_wa == iss_adr)) begin
                if (m_cnt[reg_wa] == 0) m_err = 1'b1;
                else m_cnt[reg_wa]--;
            end
        end
    endtask

    task automatic cycle(input string tag, input logic do_check);
        if (do_check)
            push_expected(tag);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] obs;
            e = exp_q.pop_front();
            case (e.kind)
                0:       obs = reg_rd[0 +: DATA_W];
                1:       obs = reg_rd[DATA_W +: DATA_W];
                2:       obs = 32'(reg_busy);
                default: obs = 32'(sb_err);
            endcase
            check(e.tag, obs, e.exp);
        end
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic drive(input string tag, input logic we, input int wa, input logic [31:0] wd,
                         input logic iv, input int ia, input int ra0, input int ra1,
                         input logic p = 1'b0);
        reset     = 1'b0;
        pause     = p;
        reg_we    = we;
        reg_wa    = ADDR_W'(wa);
        reg_wd    = wd;
        iss_valid = iv;
        iss_adr   = ADDR_W'(ia);
        reg_ra    = {ADDR_W'(ra1), ADDR_W'(ra0)};
        cycle(tag, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pause = 1'b0; reg_we = 1'b0; iss_valid = 1'b0;
        reg_wa = '0; iss_adr = '0; reg_wd = '0; reg_ra = '0;
        cycle("reset", 1'b0);
        cycle("reset", 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        drive("after_reset", 0, 0, 0, 0, 0, 5, 0);

        drive("bypass",      1, 3, 32'h1234_5678, 0, 0, 3, 0);
        drive("array_read",  0, 0, 0,             0, 0, 3, 3);
        drive("zero_write",  1, 0, 32'hFFFF_FFFF, 0, 0, 0, 3);
        drive("zero_read",   0, 0, 0,             0, 0, 0, 3);

        do_reset();
        drive("iss7_a",      0, 0, 0,             1, 7, 7, 0);
        drive("iss7_b",      0, 0, 0,             1, 7, 7, 0);
        drive("busy7",       0, 0, 0,             0, 0, 7, 7);
        drive("commit7_a",   1, 7, 32'hAAAA_0001, 0, 0, 7, 0);
        drive("commit7_b",   1, 7, 32'hAAAA_0002, 0, 0, 7, 0);
        drive("after7",      0, 0, 0,             0, 0, 7, 0);

        drive("iss9",        0, 0, 0,             1, 9, 9, 0);
        drive("iss_cmt9",    1, 9, 32'h0000_0099, 1, 9, 9, 0);
        drive("still9",      0, 0, 0,             0, 0, 9, 0);
        for (int i = 0; i < 4; i++)
            drive($sformatf("sat9_%0d", i), 0, 0, 0, 1, 9, 9, 0);
        for (int i = 0; i < 3; i++)
            drive($sformatf("drain9_%0d", i), 1, 9, 32'h900 + i, 0, 0, 9, 0);
        drive("drained9",    0, 0, 0,             0, 0, 9, 0);

        do_reset();
        drive("under12",     1, 12, 32'hC0DE_0012, 0, 0, 0, 0);
        drive("read12",      0, 0, 0,             0, 0, 12, 0);

        do_reset();
        drive("iss4",        0, 0, 0,             1, 4, 0, 0);
        drive("cmt4",        1, 4, 32'h4444_4444, 0, 0, 4, 0);
        drive("pause4",      1, 4, 32'hDEAD_BEEF, 1, 4, 4, 4, 1'b1);
        drive("paused4",     0, 0, 0,             0, 0, 4, 4);
        drive("unpause4",    1, 4, 32'hDEAD_BEEF, 1, 4, 4, 0);
        drive("after4",      0, 0, 0,             0, 0, 4, 0);

        drive("iss5_a",      0, 0, 0,             1, 5, 5, 0);
        drive("iss5_b",      0, 0, 0,             1, 5, 5, 0);
        do_reset();
        drive("rst5",        0, 0, 0,             0, 0, 5, 0);
        drive("cmt5",        1, 5, 32'h5555_5555, 0, 0, 5, 0);
        drive("err5",        0, 0, 0,             0, 0, 5, 0);

        // Random traffic on a narrow address range to force collisions.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if (n == 150) do_reset();
            drive($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                  $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 5) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
